// File: rtl/moldudp64_msg_beat_seq.sv
// Per-message beat sequencer: walks a MoldUDP64 message across DATA_BYTES-wide beats and emits lane masks.
// Optional macro MOLDUDP64_MASK_MSB_EN selects the MSB thermometer mask convention (lane 0 -> MSB).
module moldudp64_msg_beat_seq #(
  parameter int LEN_W      = 16,
  parameter int DATA_BYTES = 8,
  parameter int OFF_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  len_valid_i,
  output logic                  len_ready_o,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [OFF_W-1:0]      off_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [DATA_BYTES-1:0] beat_mask_o,
  output logic                  beat_first_o,
  output logic                  beat_last_o,
  output logic [OFF_W-1:0]      next_off_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]            state_r;
  logic [LEN_W-1:0]      rem_r;
  logic [OFF_W-1:0]      off_r;
  logic                  first_r;
  logic [OFF_W-1:0]      next_off_r;

  logic                  busy_s;
  logic                  last_s;
  logic                  fire_s;
  logic                  accept_s;
  logic [OFF_W:0]        space_s;
  logic [OFF_W:0]        take_s;
  logic [OFF_W:0]        end_s;
  logic [DATA_BYTES-1:0] mask_lsb_s;
  logic [DATA_BYTES-1:0] mask_s;

  // Lanes 0..n-1 set.
  function automatic logic [DATA_BYTES-1:0] thermo(input logic [OFF_W:0] n);
    logic [DATA_BYTES-1:0] t;
    for (int i = 0; i < DATA_BYTES; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

  // Per-beat lane arithmetic and handshake decode; off+take kept one bit wider so a full beat reads as DATA_BYTES.
  always_comb begin
    busy_s  = (state_r == ST_BUSY) && !rst;
    space_s = (OFF_W+1)'(DATA_BYTES) - {1'b0, off_r};
    last_s  = (rem_r <= LEN_W'(space_s));
    if (last_s) begin
      take_s = rem_r[OFF_W:0];
    end else begin
      take_s = space_s;
    end
    end_s      = {1'b0, off_r} + take_s;
    mask_lsb_s = thermo(end_s) & ~thermo({1'b0, off_r});
    mask_s     = {DATA_BYTES{1'b0}};
`ifdef MOLDUDP64_MASK_MSB_EN
    for (int i = 0; i < DATA_BYTES; i++) begin
      mask_s[i] = mask_lsb_s[DATA_BYTES-1-i];
    end
`else
    mask_s = mask_lsb_s;
`endif
    fire_s = busy_s && beat_ready_i;
    if (busy_s) begin
      len_ready_o = last_s && beat_ready_i;
    end else begin
      len_ready_o = !rst;
    end
    accept_s = len_valid_i && len_ready_o;
  end

  assign beat_valid_o = busy_s;
  assign beat_mask_o  = busy_s ? mask_s : {DATA_BYTES{1'b0}};
  assign beat_first_o = busy_s && first_r;
  assign beat_last_o  = busy_s && last_s;
  assign next_off_o   = next_off_r;

  // Message walk; a length accepted on the last beat overrides the return to IDLE for zero-bubble chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rem_r      <= {LEN_W{1'b0}};
      off_r      <= {OFF_W{1'b0}};
      first_r    <= 1'b0;
      next_off_r <= {OFF_W{1'b0}};
    end else begin
      if (fire_s) begin
        rem_r   <= rem_r - LEN_W'(take_s);
        off_r   <= {OFF_W{1'b0}};
        first_r <= 1'b0;
        if (last_s) begin
          next_off_r <= end_s[OFF_W-1:0];
          state_r    <= ST_IDLE;
        end
      end
      if (accept_s) begin
        rem_r   <= len_i;
        off_r   <= off_i;
        first_r <= 1'b1;
        if (len_i == {LEN_W{1'b0}}) begin
          next_off_r <= off_i;
          state_r    <= ST_IDLE;
        end else begin
          state_r <= ST_BUSY;
        end
      end
    end
  end

`ifdef FORMAL
  moldudp64_msg_beat_seq_chk #(
    .LEN_W(LEN_W), .DATA_BYTES(DATA_BYTES), .OFF_W(OFF_W)
  ) u_chk (
    .clk(clk), .rst(rst), .accept(accept_s), .len_i(len_i),
    .beat_valid(beat_valid_o), .beat_ready(beat_ready_i), .beat_last(beat_last_o),
    .mask(beat_mask_o), .take(take_s)
  );
`endif

endmodule

`ifdef FORMAL
// Property checker: mask shape and per-message byte accounting.
module moldudp64_msg_beat_seq_chk #(
  parameter int LEN_W      = 16,
  parameter int DATA_BYTES = 8,
  parameter int OFF_W      = 3
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  accept,
  input logic [LEN_W-1:0]      len_i,
  input logic                  beat_valid,
  input logic                  beat_ready,
  input logic                  beat_last,
  input logic [DATA_BYTES-1:0] mask,
  input logic [OFF_W:0]        take
);
  logic [LEN_W:0] target_r;
  logic [LEN_W:0] acc_r;
  int             edges_s;

  // Mask shape.
  always_comb begin
    edges_s = 0;
    for (int i = 0; i < DATA_BYTES - 1; i++) begin
      edges_s = edges_s + ((mask[i] != mask[i+1]) ? 1 : 0);
    end
    if (!rst) begin
      assert (edges_s <= 2);
      if (beat_valid) begin
        assert ($countones(mask) == int'(take));
      end else begin
        assert (mask == {DATA_BYTES{1'b0}});
      end
    end
  end

  // Byte accounting across a message.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_r <= {(LEN_W+1){1'b0}};
      acc_r    <= {(LEN_W+1){1'b0}};
    end else begin
      if (beat_valid && beat_ready) begin
        acc_r <= acc_r + (LEN_W+1)'($countones(mask));
        if (beat_last) begin
          assert (acc_r + (LEN_W+1)'($countones(mask)) == target_r);
        end
      end
      if (accept) begin
        target_r <= {1'b0, len_i};
        acc_r    <= {(LEN_W+1){1'b0}};
      end
    end
  end
endmodule
`endif
